switch_port_ingress: RTL

- Per-port ingress stage placed directly upstream of one switch_4port port.
- Accepts packets from a local source via a valid/ready handshake and checks the header.
- Buffers legal packets in a small FIFO.
- Replays them onto the switch port as single-cycle valid pulses, spaced by a programmable idle gap, so the switch is never overrun.
- One instance per port; its outputs drive that port's valid_in, source_in, target_in and data_in.

---
 rtl/switch_port_ingress.sv | 135 +++++++++++++
 1 files changed

// File: rtl/switch_port_ingress.sv
// Per-port ingress stage: header check, small FIFO, and paced single-cycle replay onto one switch port.
// Optional SWITCH_INGRESS_STATS_EN adds saturating accepted/dropped packet counters.
module switch_port_ingress #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_source,
  input  logic [3:0]               in_target,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [3:0]               out_source,
  output logic [3:0]               out_target,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drop_pulse,
  output logic [1:0]               fsm_state
`ifdef SWITCH_INGRESS_STATS_EN
  ,
  output logic [15:0]              acc_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             EW       = DATA_W + 8;
  localparam logic [3:0]     SRC_CODE = 4'(1 << PORT_ID);
  localparam logic [3:0]     GAP_L    = 4'(GAP);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;

  // Handshake: a beat transfers on a rising edge with in_valid && in_ready; in_ready
  // depends only on FIFO fullness, and the source holds its fields while stalled.
  logic              accept, legal, push, pop, tgt_onehot;
  logic              full, empty, slot;
  logic [AW:0]       wptr, rptr;
  logic [EW-1:0]     mem [DEPTH];
  state_t            state, state_n;
  logic [3:0]        gap_cnt, gap_n;

  assign tgt_onehot = (in_target != 4'd0) && ((in_target & (in_target - 4'd1)) == 4'd0);
  assign legal      = (in_source == SRC_CODE) && tgt_onehot && (in_target != in_source);
  assign accept     = in_valid && in_ready;
  assign push       = accept && legal;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty      = (wptr == rptr);
  assign in_ready   = !full;
  assign fifo_count = wptr - rptr;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {in_source, in_target, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      drop_pulse <= accept && !legal;
    end
  end

  // The last WAIT cycle doubles as the issue slot so pulse starts land GAP+1 cycles apart.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    slot    = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: slot = 1'b1;
      SEND: begin
        if (GAP == 0) begin
          slot = 1'b1;
        end else begin
          state_n = WAIT;
          gap_n   = GAP_L;
        end
      end
      WAIT: begin
        if (gap_cnt <= 4'd1) slot = 1'b1;
        else                 gap_n = gap_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
    if (slot) begin
      if (!empty) begin
        pop     = 1'b1;
        state_n = SEND;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      out_valid  <= 1'b0;
      out_source <= 4'd0;
      out_target <= 4'd0;
      out_data   <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      out_valid <= pop;
      if (pop) {out_source, out_target, out_data} <= mem[rptr[AW-1:0]];
    end
  end

`ifdef SWITCH_INGRESS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      if (push && (acc_cnt != 16'hFFFF))              acc_cnt  <= acc_cnt + 16'd1;
      if (accept && !legal && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
